// File: rtl/color_track_pkg.sv
// Shared types and helpers for the multi-channel colour tracker.
// Provides the per-channel state enum, the inclusive range compare, and the
// bit-offset helpers used to slice the packed threshold buses {B,G,R}.
package color_track_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, LOCKED} ch_state_t;

  // Component order inside one channel's threshold slice (R in the LSBs).
  localparam int COMP_R = 0;
  localparam int COMP_G = 1;
  localparam int COMP_B = 2;

  // Widest threshold the range helper accepts; narrower values are
  // zero-extended, which leaves an unsigned compare unchanged.
  localparam int MAX_TB = 16;

  function automatic logic in_range(input logic [MAX_TB-1:0] comp,
                                    input logic [MAX_TB-1:0] lo,
                                    input logic [MAX_TB-1:0] hi);
    // lo > hi can never satisfy both bounds, so such a window never matches.
    return (comp >= lo) && (comp <= hi);
  endfunction

  // LSB of one component bound inside a channel's 3*tb-bit slice.
  function automatic int comp_lsb(input int comp, input int tb);
    return comp * tb;
  endfunction

  // LSB of channel ch's 3*tb-bit slice inside the packed NUM_CH bus.
  function automatic int ch_thr_lsb(input int ch, input int tb);
    return ch * 3 * tb;
  endfunction

endpackage

// File: rtl/color_track_ch.sv
// One colour channel: latched thresholds, match logic, run-length FSM and
// locked-position registers.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i             pixel qualifier
//   r_i, g_i, b_i       pixel colour (CW bits)
//   x_i, y_i            pixel position (PW bits)
//   new_frame_i         frame start strobe (latches thresholds, arms channel)
//   end_frame_i         frame end strobe
//   thr_lo_i, thr_hi_i  this channel's {B,G,R} bounds (3*TB bits)
//   active_o            channel is inside a frame (state != IDLE)
//   detect_o            1-cycle pulse after the lock transition
//   x_o, y_o            first pixel of the accepted run
//   found_o             channel locked in the last completed frame
module color_track_ch
  import color_track_pkg::*;
#(
  parameter int CW      = 10,
  parameter int TB      = 5,
  parameter int PW      = 13,
  parameter int MIN_RUN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [CW-1:0]   r_i,
  input  logic [CW-1:0]   g_i,
  input  logic [CW-1:0]   b_i,
  input  logic [PW-1:0]   x_i,
  input  logic [PW-1:0]   y_i,
  input  logic            new_frame_i,
  input  logic            end_frame_i,
  input  logic [3*TB-1:0] thr_lo_i,
  input  logic [3*TB-1:0] thr_hi_i,
  output logic            active_o,
  output logic            detect_o,
  output logic [PW-1:0]   x_o,
  output logic [PW-1:0]   y_o,
  output logic            found_o
);

  localparam int RW = $clog2(MIN_RUN + 1);
  localparam logic [RW-1:0] RUN_LOCK = RW'(MIN_RUN);
  localparam int R_LSB = comp_lsb(COMP_R, TB);
  localparam int G_LSB = comp_lsb(COMP_G, TB);
  localparam int B_LSB = comp_lsb(COMP_B, TB);

  ch_state_t       state_q;
  logic [RW-1:0]   run_q;
  logic [3*TB-1:0] thr_lo_q, thr_hi_q;
  logic [PW-1:0]   cand_x_q, cand_y_q;
  logic [PW-1:0]   x_q, y_q;
  logic            detect_q, found_q;
  logic            match;

  assign match = in_range(MAX_TB'(r_i[CW-1 -: TB]), MAX_TB'(thr_lo_q[R_LSB +: TB]),
                          MAX_TB'(thr_hi_q[R_LSB +: TB]))
              && in_range(MAX_TB'(g_i[CW-1 -: TB]), MAX_TB'(thr_lo_q[G_LSB +: TB]),
                          MAX_TB'(thr_hi_q[G_LSB +: TB]))
              && in_range(MAX_TB'(b_i[CW-1 -: TB]), MAX_TB'(thr_lo_q[B_LSB +: TB]),
                          MAX_TB'(thr_hi_q[B_LSB +: TB]));

  // NOTE: state is updated with non-blocking assignments only, so every read
  // below sees the value from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= '0;
      thr_lo_q <= '0;
      thr_hi_q <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      detect_q <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      detect_q <= 1'b0;

      if (end_frame_i && (state_q != IDLE)) begin
        found_q <= (state_q == LOCKED);
        state_q <= IDLE;
        run_q   <= '0;
      end

      // NOTE: when both strobes arrive together the later assignment wins,
      // so end-of-frame bookkeeping happens and the channel still re-arms.
      if (new_frame_i) begin
        thr_lo_q <= thr_lo_i;
        thr_hi_q <= thr_hi_i;
        state_q  <= ARMED;
        run_q    <= '0;
      end else if (valid_i && !end_frame_i) begin
        unique case (state_q)
          ARMED: begin
            if (match) begin
              cand_x_q <= x_i;
              cand_y_q <= y_i;
              run_q    <= RW'(1);
              if (MIN_RUN == 1) begin
                state_q  <= LOCKED;
                detect_q <= 1'b1;
                x_q      <= x_i;
                y_q      <= y_i;
              end else begin
                state_q  <= RUN;
              end
            end
          end
          RUN: begin
            if (!match) begin
              state_q <= ARMED;
              run_q   <= '0;
            end else if (y_i != cand_y_q) begin
              // Matching pixel on another row starts a fresh candidate.
              cand_x_q <= x_i;
              cand_y_q <= y_i;
              run_q    <= RW'(1);
            end else begin
              if (run_q != RUN_LOCK) run_q <= run_q + RW'(1);
              if (run_q + RW'(1) == RUN_LOCK) begin
                state_q  <= LOCKED;
                detect_q <= 1'b1;
                x_q      <= cand_x_q;
                y_q      <= cand_y_q;
              end
            end
          end
          default: ;  // IDLE waits for new_frame; LOCKED ignores pixels
        endcase
      end
    end
  end

  assign active_o = (state_q != IDLE);
  assign detect_o = detect_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign found_o  = found_q;

endmodule

// File: rtl/color_track_multi.sv
// Multi-channel first-run colour detector between the CCD pixel stream and
// the game/display logic. Each channel reports the first pixel of the first
// horizontal run of MIN_RUN matching pixels in a frame.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid                  pixel qualifier
//   i_R, i_G, i_B            pixel colour
//   i_X_pos, i_Y_pos         pixel position
//   new_frame, end_frame     frame strobes
//   i_thr_lo, i_thr_hi       per-channel {B,G,R} bounds, ch0 in LSBs
//   o_detect                 per-channel lock pulse
//   o_X_pos, o_Y_pos         per-channel locked position, ch0 in LSBs
//   o_found                  per-channel lock flags of last completed frame
//   o_frame_done             1-cycle pulse after an end_frame inside a frame
module color_track_multi
  import color_track_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CW      = 10,
  parameter int TB      = 5,
  parameter int PW      = 13,
  parameter int MIN_RUN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [CW-1:0]          i_R,
  input  logic [CW-1:0]          i_G,
  input  logic [CW-1:0]          i_B,
  input  logic [PW-1:0]          i_X_pos,
  input  logic [PW-1:0]          i_Y_pos,
  input  logic                   new_frame,
  input  logic                   end_frame,
  input  logic [NUM_CH*3*TB-1:0] i_thr_lo,
  input  logic [NUM_CH*3*TB-1:0] i_thr_hi,
  output logic [NUM_CH-1:0]      o_detect,
  output logic [NUM_CH*PW-1:0]   o_X_pos,
  output logic [NUM_CH*PW-1:0]   o_Y_pos,
  output logic [NUM_CH-1:0]      o_found,
  output logic                   o_frame_done
);

  logic [NUM_CH-1:0] active;
  logic              frame_done_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    color_track_ch #(
      .CW      (CW),
      .TB      (TB),
      .PW      (PW),
      .MIN_RUN (MIN_RUN)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (i_valid),
      .r_i         (i_R),
      .g_i         (i_G),
      .b_i         (i_B),
      .x_i         (i_X_pos),
      .y_i         (i_Y_pos),
      .new_frame_i (new_frame),
      .end_frame_i (end_frame),
      .thr_lo_i    (i_thr_lo[ch_thr_lsb(c, TB) +: 3*TB]),
      .thr_hi_i    (i_thr_hi[ch_thr_lsb(c, TB) +: 3*TB]),
      .active_o    (active[c]),
      .detect_o    (o_detect[c]),
      .x_o         (o_X_pos[c*PW +: PW]),
      .y_o         (o_Y_pos[c*PW +: PW]),
      .found_o     (o_found[c])
    );
  end

  // All channels enter and leave frames together, so any active channel
  // means a frame is open and end_frame closes it.
  always_ff @(posedge clk) begin
    if (rst) frame_done_q <= 1'b0;
    else     frame_done_q <= end_frame && (|active);
  end

  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_color_track_multi.sv
module tb_color_track_multi;

  localparam int CW = 10;
  localparam int TB = 5;
  localparam int PW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0, new_frame = 1'b0, end_frame = 1'b0;
  logic [CW-1:0] r = '0, g = '0, b = '0;
  logic [PW-1:0] xp = '0, yp = '0;
  logic [29:0] thr_lo = '0, thr_hi = '0;

  logic [1:0]  det [2];
  logic [25:0] xo  [2];
  logic [25:0] yo  [2];
  logic [1:0]  fnd [2];
  logic        done[2];

  always #5 clk = ~clk;

  // dut0: MIN_RUN=4, dut1: MIN_RUN=1; both see the same stimulus.
  color_track_multi #(.MIN_RUN(4)) dut0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_R(r), .i_G(g), .i_B(b),
    .i_X_pos(xp), .i_Y_pos(yp), .new_frame(new_frame), .end_frame(end_frame),
    .i_thr_lo(thr_lo), .i_thr_hi(thr_hi), .o_detect(det[0]), .o_X_pos(xo[0]),
    .o_Y_pos(yo[0]), .o_found(fnd[0]), .o_frame_done(done[0]));

  color_track_multi #(.MIN_RUN(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_R(r), .i_G(g), .i_B(b),
    .i_X_pos(xp), .i_Y_pos(yp), .new_frame(new_frame), .end_frame(end_frame),
    .i_thr_lo(thr_lo), .i_thr_hi(thr_hi), .o_detect(det[1]), .o_X_pos(xo[1]),
    .o_Y_pos(yo[1]), .o_found(fnd[1]), .o_frame_done(done[1]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the list of accepted pixels of the current frame per channel; a
  // channel locks when the last n accepted pixels all match and share a row.
  typedef struct { bit m; int x; int y; } pix_t;
  pix_t hist0[$];
  pix_t hist1[$];
  int   mr[2] = '{4, 1};
  bit   in_frame;
  bit [29:0] m_lo, m_hi;
  bit   e_det [2][2];
  int   e_x   [2][2];
  int   e_y   [2][2];
  bit   e_fnd [2][2];
  bit   e_done[2];
  bit   locked[2][2];

  function automatic bit model_match(input int c, input int rr, input int gg, input int bb);
    int comp[3];
    int lo, hi;
    comp[0] = rr >> (CW - TB);
    comp[1] = gg >> (CW - TB);
    comp[2] = bb >> (CW - TB);
    for (int k = 0; k < 3; k++) begin
      lo = int'(m_lo >> ((c*3 + k)*TB)) & ((1 << TB) - 1);
      hi = int'(m_hi >> ((c*3 + k)*TB)) & ((1 << TB) - 1);
      if (comp[k] < lo || comp[k] > hi) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit tail_lock(input pix_t h[$], input int n, output pix_t first);
    int s = h.size();
    first = '{1'b0, 0, 0};
    if (s < n) return 1'b0;
    for (int k = s - n; k < s; k++)
      if (!h[k].m || h[k].y != h[s-1].y) return 1'b0;
    first = h[s-n];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    pix_t p, f;
    bit   hit;
    if (rst) begin
      in_frame = 1'b0; m_lo = '0; m_hi = '0;
      hist0.delete(); hist1.delete();
      for (int i = 0; i < 2; i++) begin
        e_done[i] = 1'b0;
        for (int c = 0; c < 2; c++) begin
          e_det[i][c] = 0; e_x[i][c] = 0; e_y[i][c] = 0; e_fnd[i][c] = 0; locked[i][c] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_done[i] = 1'b0;
        for (int c = 0; c < 2; c++) e_det[i][c] = 1'b0;
      end
      if (end_frame && in_frame) begin
        in_frame = 1'b0;
        for (int i = 0; i < 2; i++) begin
          e_done[i] = 1'b1;
          for (int c = 0; c < 2; c++) e_fnd[i][c] = locked[i][c];
        end
      end
      if (new_frame) begin
        in_frame = 1'b1; m_lo = thr_lo; m_hi = thr_hi;
        hist0.delete(); hist1.delete();
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < 2; c++) locked[i][c] = 1'b0;
      end else if (in_frame && i_valid && !end_frame) begin
        for (int c = 0; c < 2; c++) begin
          p.m = model_match(c, int'(r), int'(g), int'(b));
          p.x = int'(xp);
          p.y = int'(yp);
          if (c == 0) hist0.push_back(p); else hist1.push_back(p);
          for (int i = 0; i < 2; i++) begin
            hit = (c == 0) ? tail_lock(hist0, mr[i], f) : tail_lock(hist1, mr[i], f);
            if (!locked[i][c] && hit) begin
              locked[i][c] = 1'b1;
              e_det[i][c]  = 1'b1;
              e_x[i][c]    = f.x;
              e_y[i][c]    = f.y;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d_frame_done", i), 32'(done[i]), 32'(e_done[i]));
        for (int c = 0; c < 2; c++) begin
          check($sformatf("dut%0d_detect%0d", i, c), 32'(det[i][c]), 32'(e_det[i][c]));
          check($sformatf("dut%0d_x%0d", i, c), 32'(xo[i][c*PW +: PW]), e_x[i][c]);
          check($sformatf("dut%0d_y%0d", i, c), 32'(yo[i][c*PW +: PW]), e_y[i][c]);
          check($sformatf("dut%0d_found%0d", i, c), 32'(fnd[i][c]), 32'(e_fnd[i][c]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // kind: 0 = matches nothing, 1 = ch0 colour, 2 = ch1 colour
  task automatic cyc(input bit v, input bit nf, input bit ef, input int x, input int y, input int kind);
    i_valid = v; new_frame = nf; end_frame = ef;
    xp = PW'(x); yp = PW'(y);
    case (kind)
      1:       begin r = '0;         g = CW'(640); b = '0; end
      2:       begin r = CW'(800);   g = '0;       b = '0; end
      default: begin r = '0;         g = '0;       b = '0; end
    endcase
    @(posedge clk); #1;
    i_valid = 1'b0; new_frame = 1'b0; end_frame = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input int kind);
    cyc(1'b1, 1'b0, 1'b0, x, y, kind);
  endtask
  task automatic nf();   cyc(1'b0, 1'b1, 1'b0, 0, 0, 0); endtask
  task automatic ef();   cyc(1'b0, 1'b0, 1'b1, 0, 0, 0); endtask
  task automatic idle(); cyc(1'b0, 1'b0, 1'b0, 0, 0, 0); endtask

  // Packed {B,G,R} bounds per channel
  localparam logic [14:0] CH0_LO    = {5'd0,  5'd17, 5'd0};
  localparam logic [14:0] CH0_HI    = {5'd10, 5'd31, 5'd10};
  localparam logic [14:0] NEVER_LO  = {5'd31, 5'd31, 5'd31};
  localparam logic [14:0] NEVER_HI  = {5'd0,  5'd0,  5'd0};
  localparam logic [14:0] CH1_LO    = {5'd0,  5'd0,  5'd20};
  localparam logic [14:0] CH1_HI    = {5'd5,  5'd5,  5'd31};

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_detect", 32'(det[0]), 32'd0);
    check("reset_x", 32'(xo[0]), 32'd0);
    check("reset_found", 32'(fnd[0]), 32'd0);
    check("reset_done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    idle();

    // 1: basic run of four on row 5
    thr_lo = {NEVER_LO, CH0_LO};
    thr_hi = {NEVER_HI, CH0_HI};
    nf();
    for (int x = 20; x <= 23; x++) pix(x, 5, 1);
    check("t1_detect", 32'(det[0]), 32'h1);
    check("t1_x", 32'(xo[0][12:0]), 32'd20);
    check("t1_y", 32'(yo[0][12:0]), 32'd5);
    check("t1_run1_x", 32'(xo[1][12:0]), 32'd20);
    idle();
    check("t1_single_pulse", 32'(det[0]), 32'h0);
    ef();
    check("t1_done", 32'(done[0]), 32'd1);
    check("t1_found", 32'(fnd[0]), 32'h1);

    // 2: broken run, then a clean run at x=30
    nf();
    for (int x = 20; x <= 22; x++) pix(x, 5, 1);
    pix(23, 5, 0);
    for (int x = 30; x <= 33; x++) pix(x, 5, 1);
    check("t2_x", 32'(xo[0][12:0]), 32'd30);
    ef();

    // 3: run split across rows does not lock; same-row run does
    nf();
    pix(638, 5, 1); pix(639, 5, 1); pix(0, 6, 1); pix(1, 6, 1);
    check("t3_no_lock", 32'(det[0]), 32'h0);
    pix(0, 6, 1); pix(1, 6, 1); pix(2, 6, 1); pix(3, 6, 1);
    check("t3_x", 32'(xo[0][12:0]), 32'd0);
    check("t3_y", 32'(yo[0][12:0]), 32'd6);
    ef();

    // 4: both channels, disjoint windows
    thr_lo = {CH1_LO, CH0_LO};
    thr_hi = {CH1_HI, CH0_HI};
    nf();
    for (int x = 100; x <= 103; x++) pix(x, 7, 2);
    check("t4_ch1_detect", 32'(det[0]), 32'h2);
    for (int x = 200; x <= 203; x++) pix(x, 8, 1);
    ef();
    check("t4_found", 32'(fnd[0]), 32'h3);
    check("t4_ch1_x", 32'(xo[0][25:13]), 32'd100);
    check("t4_ch1_y", 32'(yo[0][25:13]), 32'd7);
    check("t4_ch0_x", 32'(xo[0][12:0]), 32'd200);

    // 5: mid-frame threshold change has no effect
    nf();
    thr_lo = {CH1_LO, NEVER_LO};
    thr_hi = {CH1_HI, NEVER_HI};
    for (int x = 40; x <= 43; x++) pix(x, 9, 1);
    check("t5_lock_old_thr", 32'(xo[0][12:0]), 32'd40);
    cyc(1'b1, 1'b1, 1'b1, 44, 9, 1);   // new_frame + end_frame together
    check("t5_done", 32'(done[0]), 32'd1);
    check("t5_found", 32'(fnd[0]), 32'h1);
    for (int x = 45; x <= 48; x++) pix(x, 9, 1);
    check("t5_new_thr_no_lock", 32'(det[0]), 32'h0);
    thr_lo = {CH1_LO, CH0_LO};
    thr_hi = {CH1_HI, CH0_HI};

    // new_frame without end_frame restarts the run
    nf();
    pix(50, 11, 1); pix(51, 11, 1);
    nf();
    pix(52, 11, 1); pix(53, 11, 1);
    check("t5_restart_no_lock", 32'(det[0]), 32'h0);
    pix(54, 11, 1); pix(55, 11, 1);
    check("t5_restart_x", 32'(xo[0][12:0]), 32'd52);
    ef();

    // frame with no matches
    nf();
    for (int x = 0; x < 3; x++) pix(x, 12, 0);
    ef();
    check("t4_nomatch_done", 32'(done[0]), 32'd1);
    check("t4_nomatch_found", 32'(fnd[0]), 32'h0);
    check("t4_nomatch_keep_x", 32'(xo[0][12:0]), 32'd52);

    // 6: reset while in RUN
    nf();
    for (int x = 60; x <= 62; x++) pix(x, 10, 1);
    rst = 1'b1;
    pix(63, 10, 1);
    rst = 1'b0;
    check("t6_rst_x", 32'(xo[0]), 32'd0);
    check("t6_rst_y", 32'(yo[1]), 32'd0);
    check("t6_rst_found", 32'(fnd[0]), 32'h0);
    for (int x = 64; x <= 67; x++) pix(x, 10, 1);
    check("t6_ignored", 32'(det[0]), 32'h0);
    ef();
    check("t6_no_done", 32'(done[0]), 32'd0);
    idle(); idle();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
